// File: rtl/alu_result_collector_if.sv
// alu_result_collector_if: ALU result handshake between the producer and the collector.
interface alu_result_collector_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int DEST_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_cout;
    logic [3:0]        in_status;
    logic              in_set_flags;
    logic [DEST_W-1:0] in_dest;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DEST_W-1:0] out_dest;
    logic [3:0]        flags;
    logic [CW-1:0]     count;
    modport master (
        output flush, in_valid, in_result, in_cout, in_status, in_set_flags, in_dest, out_ready,
        input  in_ready, out_valid, out_result, out_dest, flags, count
    );
    modport slave (
        input  flush, in_valid, in_result, in_cout, in_status, in_set_flags, in_dest, out_ready,
        output in_ready, out_valid, out_result, out_dest, flags, count
    );
endinterface

// File: rtl/alu_result_collector.sv
// alu_result_collector: FWFT result FIFO for write-back plus the architectural {V,C,N,Z} flag register.
module alu_result_collector #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int DEST_W = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    alu_result_collector_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DATA_W-1:0] res_mem  [DEPTH];
    logic [DEST_W-1:0] dest_mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [3:0]        flags_q, flags_d;
    logic              push, pop, keep;
    assign bus.in_ready   = count_q != CW'(DEPTH);
    assign bus.out_valid  = count_q != '0;
    assign bus.out_result = bus.out_valid ? res_mem[rd_ptr_q] : '0;
    assign bus.out_dest   = bus.out_valid ? dest_mem[rd_ptr_q] : '0;
    assign bus.flags      = flags_q;
    assign bus.count      = count_q;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign keep = push && !bus.flush;
    always_comb begin
        wr_ptr_d = bus.flush ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = bus.flush ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
        // carry comes from cOut, not from the status C bit
        flags_d  = keep && bus.in_set_flags
                 ? {bus.in_status[3], bus.in_cout, bus.in_status[1], bus.in_status[0]} : flags_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end
    always_ff @(posedge clk) begin
        if (keep) begin
            res_mem[wr_ptr_q]  <= bus.in_result;
            dest_mem[wr_ptr_q] <= bus.in_dest;
        end
    end
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed and random checks of the collector against a queue-based model.
module tb_alu_result_collector;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;
    localparam int DEST_W = 5;
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [DEST_W-1:0] dest;
    } entry_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    entry_t q[$];
    logic [3:0] m_flags = 4'b0000;
    alu_result_collector_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DEST_W(DEST_W)) bus ();
    alu_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic check_all();
        entry_t h;
        h = q.size() > 0 ? q[0] : '0;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("flags", 64'(bus.flags), 64'(m_flags));
        chk("out_result", bus.out_result, h.res);
        chk("out_dest", 64'(bus.out_dest), 64'(h.dest));
    endtask
    task automatic step(input logic v, input logic r, input logic fl, input logic [DATA_W-1:0] res,
                        input logic co, input logic [3:0] st, input logic sf, input logic [DEST_W-1:0] d);
        bit do_push, do_pop;
        bus.in_valid = v; bus.out_ready = r; bus.flush = fl; bus.in_result = res;
        bus.in_cout = co; bus.in_status = st; bus.in_set_flags = sf; bus.in_dest = d;
        do_push = v && q.size() < DEPTH;
        do_pop  = r && q.size() > 0;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back('{res: res, dest: d});
                if (sf) m_flags = {st[3], co, st[1], st[0]};
            end
        end
        #1 check_all();
    endtask
    task automatic idle(input logic r);
        step(1'b0, r, 1'b0, '0, 1'b0, 4'b0000, 1'b0, '0);
    endtask
    initial begin
        logic v, r, fl, co, sf;
        logic [DATA_W-1:0] res;
        logic [3:0] st;
        logic [DEST_W-1:0] d;
        bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0; bus.in_result = '0;
        bus.in_cout = 0; bus.in_status = '0; bus.in_set_flags = 0; bus.in_dest = '0;
        #12 check_all();
        rst_n = 1'b1;
        // single push with immediate drain: visible one cycle after push, no bypass
        step(1'b1, 1'b1, 1'b0, 64'd4, 1'b0, 4'b0000, 1'b1, 5'd5);
        chk("t2_res", bus.out_result, 64'd4);
        idle(1'b1);
        // fill to full, hold a third result, then drain in order
        step(1'b1, 1'b0, 1'b0, 64'd4, 1'b0, 4'b0000, 1'b0, 5'd1);
        step(1'b1, 1'b0, 1'b0, 64'd5, 1'b0, 4'b0000, 1'b0, 5'd2);
        step(1'b1, 1'b0, 1'b0, 64'd6, 1'b0, 4'b0000, 1'b0, 5'd3);
        chk("t3_ready_full", 64'(bus.in_ready), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'd6, 1'b0, 4'b0000, 1'b0, 5'd3);
        step(1'b1, 1'b1, 1'b0, 64'd6, 1'b0, 4'b0000, 1'b0, 5'd3);
        idle(1'b1);
        idle(1'b1);
        // flag update only when requested
        step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 4'b0001, 1'b1, 5'd7);
        step(1'b1, 1'b1, 1'b0, -64'sd2, 1'b0, 4'b0010, 1'b0, 5'd8);
        chk("t4_flags", 64'(bus.flags), 64'h1);
        step(1'b1, 1'b1, 1'b0, 64'd0, 1'b1, 4'b1001, 1'b1, 5'd9);
        chk("t5_flags", 64'(bus.flags), 64'hd);
        idle(1'b1);
        // flush with a simultaneous push
        step(1'b1, 1'b0, 1'b0, 64'd11, 1'b0, 4'b0000, 1'b0, 5'd4);
        step(1'b1, 1'b1, 1'b1, 64'd12, 1'b0, 4'b0010, 1'b1, 5'd6);
        chk("t6_flags", 64'(bus.flags), 64'hd);
        // random traffic with producer hold while stalled
        v = 0; res = '0; co = 0; st = '0; sf = 0; d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(v && q.size() == DEPTH)) begin
                v = $urandom_range(0, 3) != 0;
                res = {$urandom, $urandom};
                co = 1'($urandom);
                st = 4'($urandom);
                sf = 1'($urandom);
                d = 5'($urandom);
            end
            r = $urandom_range(0, 2) != 0;
            fl = $urandom_range(0, 15) == 0;
            step(v, r, fl, res, co, st, sf, d);
        end
        // asynchronous reset in the middle of traffic
        step(1'b1, 1'b0, 1'b0, 64'habc, 1'b1, 4'b1111, 1'b1, 5'd1);
        step(1'b1, 1'b0, 1'b0, 64'hdef, 1'b1, 4'b1111, 1'b1, 5'd2);
        #2 rst_n = 1'b0;
        q.delete();
        m_flags = 4'b0000;
        #1 check_all();
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
